// File: rtl/serializador_pkg.sv
// Shared types and helpers for the sensor-link frame serializer.
package serializador_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } estado_e;

  localparam int         HDR_W_DEF   = 6;
  localparam logic [5:0] HDR_VAL_DEF = 6'b111110;
  localparam int         TRL_W_DEF   = 3;
  localparam logic [2:0] TRL_VAL_DEF = 3'b011;

  function automatic int frame_w(input int hdr_w, input int data_w,
                                 input int par_en, input int trl_w);
    return hdr_w + data_w + par_en + trl_w;
  endfunction

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/contador_bits.sv
// Down-counter with synchronous load and a zero flag; saturates at zero.
module contador_bits #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serializador_tramas.sv
// Parallel-to-serial frame transmitter: header, data MSB first, optional
// parity, trailer; supports back-to-back frames and continuous repeat.
module serializador_tramas
  import serializador_pkg::*;
#(
  parameter int                DATA_W     = 7,
  parameter int                HDR_W      = HDR_W_DEF,
  parameter logic [HDR_W-1:0]  HDR_VAL    = HDR_VAL_DEF,
  parameter int                TRL_W      = TRL_W_DEF,
  parameter logic [TRL_W-1:0]  TRL_VAL    = TRL_VAL_DEF,
  parameter bit                PARITY_EN  = 1'b0,
  parameter bit                PARITY_ODD = 1'b0,
  parameter logic              IDLE_LVL   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              cont_mode,
  output logic              dserie,
  output logic              busy,
  output logic              frame_done
);

  localparam int FRAME_W = frame_w(HDR_W, DATA_W, int'(PARITY_EN), TRL_W);
  localparam int CNT_W   = clog2(FRAME_W);

  estado_e              estado_q;
  logic [FRAME_W-1:0]   sreg_q, frame_q, frame_in, frame_d;
  logic                 dserie_q, busy_q, done_q;
  logic [CNT_W-1:0]     cnt;
  logic                 cnt_zero, carga, dec;

  generate
    if (PARITY_EN) begin : g_par
      logic par;
      assign par      = (^din) ^ PARITY_ODD;
      assign frame_in = {HDR_VAL, din, par, TRL_VAL};
    end else begin : g_nopar
      assign frame_in = {HDR_VAL, din, TRL_VAL};
    end
  endgenerate

  // Ready depends only on state and counter, so it can never loop back on din_valid.
  assign din_ready = (estado_q == ST_IDLE) | ((estado_q == ST_SHIFT) & cnt_zero);
  assign carga     = din_ready & (din_valid | ((estado_q == ST_SHIFT) & cont_mode));
  assign frame_d   = din_valid ? frame_in : frame_q;
  assign dec       = (estado_q == ST_SHIFT) & ~cnt_zero;

  contador_bits #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (carga),
    .load_val_i (CNT_W'(FRAME_W - 1)),
    .dec_i      (dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= ST_IDLE;
      sreg_q   <= '0;
      frame_q  <= '0;
      dserie_q <= IDLE_LVL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (carga) begin
      // MSB goes straight to the line; the rest waits in the shift register.
      estado_q <= ST_SHIFT;
      frame_q  <= frame_d;
      sreg_q   <= {frame_d[FRAME_W-2:0], 1'b0};
      dserie_q <= frame_d[FRAME_W-1];
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      case (estado_q)
        ST_SHIFT: begin
          if (cnt_zero) begin
            estado_q <= ST_IDLE;
            dserie_q <= IDLE_LVL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
          end else begin
            sreg_q   <= {sreg_q[FRAME_W-2:0], 1'b0};
            dserie_q <= sreg_q[FRAME_W-1];
            done_q   <= (cnt == CNT_W'(1));
          end
        end
        default: begin
          dserie_q <= IDLE_LVL;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dserie     = dserie_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_serializador_tramas.sv
// Directed bench for serializador_tramas: default build plus an even-parity build.
module tb_serializador_tramas;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] din;
  logic       valid_a, valid_b, cont_mode;
  logic       ready_a, dserie_a, busy_a, done_a;
  logic       ready_b, dserie_b, busy_b, done_b;
  int         ntot = 0;
  int         npass = 0;
  int         nfail = 0;

  always #5 clk = ~clk;

  serializador_tramas dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(valid_a), .din_ready(ready_a),
    .cont_mode(cont_mode), .dserie(dserie_a), .busy(busy_a), .frame_done(done_a)
  );

  serializador_tramas #(.PARITY_EN(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(valid_b), .din_ready(ready_b),
    .cont_mode(1'b0), .dserie(dserie_b), .busy(busy_b), .frame_done(done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag, input bit sel);
    chk({tag, "_dserie"}, sel ? dserie_b : dserie_a, 1);
    chk({tag, "_busy"},   sel ? busy_b   : busy_a,   0);
    chk({tag, "_done"},   sel ? done_b   : done_a,   0);
    chk({tag, "_ready"},  sel ? ready_b  : ready_a,  1);
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) valid_b = v;
    else     valid_a = v;
  endtask

  // Checks n frame bits (exp MSB first); optional mid-frame poke at bit pk,
  // and at the last bit applies the next din/valid/cont before the edge.
  task automatic run_frame(input string tag, input logic [31:0] exp, input int n,
                           input bit sel, input int pk, input logic [6:0] pk_din,
                           input logic [6:0] nxt_din, input logic nxt_valid,
                           input logic nxt_cont);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_b%0d", tag, i), sel ? dserie_b : dserie_a, exp[n-1-i]);
      chk($sformatf("%s_busy%0d", tag, i), sel ? busy_b : busy_a, 1);
      chk($sformatf("%s_done%0d", tag, i), sel ? done_b : done_a, (i == n-1));
      chk($sformatf("%s_rdy%0d", tag, i), sel ? ready_b : ready_a, (i == n-1));
      if (pk >= 0 && i == pk) begin
        din = pk_din;
        set_valid(sel, 1'b1);
      end else if (pk >= 0 && i == pk + 1) begin
        set_valid(sel, 1'b0);
      end
      if (i == n-1) begin
        din       = nxt_din;
        cont_mode = nxt_cont;
        set_valid(sel, nxt_valid);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; din = '0; valid_a = 1'b0; valid_b = 1'b0; cont_mode = 1'b0;
    tick(); tick();
    idle_chk("rst_a", 0);
    idle_chk("rst_b", 1);
    rst_n = 1'b1;
    tick();

    // Single frame with defaults
    din = 7'b1010011; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    run_frame("single", 32'b1111101010011011, 16, 0, -1, 7'h0, 7'h0, 1'b0, 1'b0);
    idle_chk("single_end", 0);

    // Even parity, four ones -> 0
    din = 7'b1010011; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    run_frame("par0", 32'b11111010100110011, 17, 1, -1, 7'h0, 7'h0, 1'b0, 1'b0);
    idle_chk("par0_end", 1);

    // Even parity, one one -> 1
    din = 7'b1000000; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    run_frame("par1", 32'b11111010000001011, 17, 1, -1, 7'h0, 7'h0, 1'b0, 1'b0);
    idle_chk("par1_end", 1);

    // Back-to-back: valid held, 0x2A offered at the first last-bit cycle
    din = 7'h55; valid_a = 1'b1;
    tick();
    run_frame("b2b1", 32'b1111101010101011, 16, 0, -1, 7'h0, 7'h2A, 1'b1, 1'b0);
    valid_a = 1'b0;
    run_frame("b2b2", 32'b1111100101010011, 16, 0, -1, 7'h0, 7'h0, 1'b0, 1'b0);
    idle_chk("b2b_end", 0);

    // Continuous mode: 0x7F repeats; din changes while valid is low
    cont_mode = 1'b1; din = 7'h7F; valid_a = 1'b1;
    tick();
    valid_a = 1'b0; din = 7'h00;
    run_frame("cont1", 32'b1111101111111011, 16, 0, -1, 7'h0, 7'h11, 1'b0, 1'b1);
    run_frame("cont2", 32'b1111101111111011, 16, 0, -1, 7'h0, 7'h22, 1'b0, 1'b1);
    run_frame("cont3", 32'b1111101111111011, 16, 0, -1, 7'h0, 7'h00, 1'b0, 1'b0);
    idle_chk("cont_end", 0);

    // Handshake hold-off: different word pulsed at bit 5
    din = 7'h55; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    run_frame("hold", 32'b1111101010101011, 16, 0, 5, 7'h2A, 7'h0, 1'b0, 1'b0);
    idle_chk("hold_end", 0);

    // Reset mid-frame at bit 7
    din = 7'b1010011; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("rstmid_busy_before", busy_a, 1);
    rst_n = 1'b0;
    tick();
    chk("rstmid_dserie", dserie_a, 1);
    chk("rstmid_busy",   busy_a,   0);
    chk("rstmid_done",   done_a,   0);
    rst_n = 1'b1;
    chk("rstmid_ready",  ready_a,  1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("rstmid_quiet%0d", i), {busy_a, dserie_a, done_a}, 3'b010);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/serializador_tramas.md
Name: serializador_tramas

Overview:
- Parametrised parallel-to-serial frame transmitter; next generation of the sensor-link serializer.
- Captures a DATA_W-bit sensor word (humo, pos, tempG, tempL, frec, alL, alG, …) through a valid/ready handshake and snapshots it at frame start.
- Emits header + data (MSB first) + optional parity + trailer on one serial line, one bit per clk.
- Supports back-to-back frames and a continuous repeat mode.

Parameters:
- DATA_W, 7, sensor bits per frame (1..32).
- HDR_W, 6, header width (1..16).
- HDR_VAL, 6'b111110, header pattern, sent MSB first.
- TRL_W, 3, trailer width (1..16).
- TRL_VAL, 3'b011, trailer pattern, sent MSB first.
- PARITY_EN, 0, 1 inserts a parity bit between data and trailer.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only if PARITY_EN=1).
- IDLE_LVL, 1'b1, line level when no frame is in progress.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, reset, synchronous, active-low.
- din, in, DATA_W, parallel sensor word.
- din_valid, in, 1, din is presented.
- din_ready, out, 1, block can accept din this cycle.
- cont_mode, in, 1, repeat the last frame when no new word is offered.
- dserie, out, 1, registered serial output.
- busy, out, 1, a frame bit is on dserie this cycle.
- frame_done, out, 1, high during the cycle dserie carries the last trailer bit.

Behaviour:
- FRAME_W = HDR_W + DATA_W + PARITY_EN + TRL_W; defaults give 16, the existing frame layout.
- Frame order: HDR_VAL, then din[DATA_W-1:0], then par, then TRL_VAL.
- par = ^din XOR PARITY_ODD.
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - dserie=IDLE_LVL, busy=0, frame_done=0.
  - Bit counter=0; shift register=0.
  - Any frame in progress is abandoned immediately, with no trailer.
- States:
  - IDLE: din_ready=1, dserie=IDLE_LVL, busy=0.
  - SHIFT: busy=1.
- Accept: a word is accepted when din_valid & din_ready at edge t. The full frame is loaded into the shift register and state goes to SHIFT. The frame MSB appears on dserie from t+1, so latency is 1 cycle.
- SHIFT:
  - Each edge presents the next frame bit.
  - The counter runs from FRAME_W-1 down to 0; count 0 is the last bit.
  - din_ready=1 only in the last-bit cycle (count 0).
  - din is ignored in all other SHIFT cycles; changes on din never corrupt a frame in flight.
- End of frame, at the last-bit cycle edge:
  - din_valid=1: the new frame loads; its MSB follows on the next cycle with no idle gap.
  - din_valid=0, cont_mode=1: the last accepted frame is retransmitted back-to-back.
  - din_valid=0, cont_mode=0: return to IDLE; dserie=IDLE_LVL on the next cycle.
- frame_done: single-cycle pulse aligned with the last bit. It recurs every FRAME_W cycles during back-to-back or continuous operation.
- cont_mode is sampled only at the last-bit edge. Toggling it mid-frame has no effect on the current frame.
- Outputs dserie, busy, frame_done are registered. din_ready is combinational from state and counter only, never from din_valid.
- Counter width: clog2(FRAME_W); it must not wrap below 0.

Decomposition:
- Package serializador_pkg:
  - State encoding (IDLE, SHIFT).
  - Function computing FRAME_W.
  - Function clog2.
  - Default HDR/TRL constants.
- Sub-module contador_bits: parametrised down-counter with load and zero flag. It replaces the free-running 4-bit select counter.
- The shift register and frame assembly stay in serializador_tramas.

Test Plan:
- Single frame, defaults:
  - Stimulus: din=7'b1010011 with one valid pulse in IDLE.
  - Response: dserie = 1111101010011011 over 16 cycles starting 1 cycle after accept. frame_done high on the 16th bit. Then IDLE with dserie=1, busy=0.
- Parity, PARITY_EN=1, even:
  - Stimulus: din=7'b1010011 (four ones).
  - Response: 17-bit frame 111110 1010011 0 011.
  - Repeat with din=7'b1000000: parity bit = 1.
- Back-to-back:
  - Stimulus: din_valid held high with din=7'h55, then 7'h2A presented at the first frame's last-bit cycle.
  - Response: 32 consecutive frame bits with no idle gap; din_ready high exactly at cycles 16 and 32.
- Continuous mode:
  - Stimulus: cont_mode=1, one accept of 7'h7F, then din_valid=0.
  - Response: the frame repeats every 16 cycles; frame_done every 16th cycle. Changing din while din_valid=0 does not alter the retransmitted data.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 at bit 7 of a frame.
  - Response: on the next edge dserie=1, busy=0, frame_done=0. After release, din_ready=1 and no residual bits appear.
- Handshake hold-off:
  - Stimulus: din_valid pulsed mid-frame with a different din.
  - Response: the word is ignored, din_ready=0 in that cycle, and the current frame is unchanged.
